// File: rtl/vga_bus_arbiter_pkg.sv
// Shared definitions for the VGA/system bus arbiter: FSM state encodings and
// the fixed index of the framebuffer fetcher.
package vga_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_e;

    localparam int VGA_MASTER = 0;

endpackage

// File: rtl/vga_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface vga_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2
);
    logic [NUM_MASTERS-1:0] req;
    logic                   bus_wait;
    logic [NUM_MASTERS-1:0] ack;
    logic [OWNER_W-1:0]     owner;
    logic                   owner_valid;
    logic                   timeout;

    modport master (output req, bus_wait, input ack, owner, owner_valid, timeout);
    modport slave  (input req, bus_wait, output ack, owner, owner_valid, timeout);
endinterface

// File: rtl/vga_bus_arbiter_rr_pick.sv
// Rotating-priority encoder over masters 1..N-1: first requester at or above
// i_rr_ptr, wrapping from N-1 back to 1.
module vga_bus_arbiter_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2
) (
    input  logic [NUM_MASTERS-1:1] i_req,
    input  logic [OWNER_W-1:0]     i_rr_ptr,
    output logic [OWNER_W-1:0]     o_winner,
    output logic                   o_found
);
    logic [OWNER_W-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_MASTERS - 1; i++) begin
            // Offset keeps the modulo operand non-negative; i_rr_ptr lives in 1..N-1.
            w_idx = OWNER_W'(((int'(i_rr_ptr) + NUM_MASTERS - 2 + i) % (NUM_MASTERS - 1)) + 1);
            if (!o_found && i_req[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end
endmodule

// File: rtl/vga_bus_arbiter.sv
// System bus arbiter: master 0 (VGA fetch) has fairness-limited priority, the
// rest rotate; grants are registered, with a dead cycle and a hold watchdog.
module vga_bus_arbiter
    import vga_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2,
    parameter int FAIR_LIMIT  = 4,
    parameter int MAX_HOLD    = 64
) (
    input  logic                clk25MHz,
    input  logic                reset_L,
    vga_bus_arbiter_if.slave    bus
);
    localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_ack;
    logic [NUM_MASTERS-1:0] r_blocked;
    logic [OWNER_W-1:0]     r_owner;
    logic [OWNER_W-1:0]     r_rr_ptr;
    logic                   r_owner_valid;
    logic                   r_timeout;
    logic [FAIR_W-1:0]      r_fair_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;

    logic [NUM_MASTERS-1:0] w_elig;
    logic [OWNER_W-1:0]     w_rr_winner;
    logic [OWNER_W-1:0]     w_rr_next;
    logic [OWNER_W-1:0]     w_winner;
    logic                   w_rr_found;
    logic                   w_others;
    logic                   w_pick0;
    logic                   w_any;
    logic                   w_owner_req;
    logic                   w_trip;

    // Masters revoked by the watchdog stay out of arbitration until they drop req.
    assign w_elig      = bus.req & ~r_blocked;
    assign w_others    = |w_elig[NUM_MASTERS-1:1];
    assign w_pick0     = w_elig[VGA_MASTER] &&
                         ((r_fair_cnt < FAIR_W'(FAIR_LIMIT)) || !w_others);
    assign w_any       = w_pick0 || w_rr_found;
    assign w_winner    = w_pick0 ? OWNER_W'(VGA_MASTER) : w_rr_winner;
    assign w_rr_next   = (w_rr_winner == OWNER_W'(NUM_MASTERS - 1)) ? OWNER_W'(1)
                                                                     : w_rr_winner + OWNER_W'(1);
    assign w_owner_req = bus.req[r_owner];
    assign w_trip      = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) && !bus.bus_wait;

    vga_bus_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .OWNER_W     (OWNER_W)
    ) u_rr_pick (
        .i_req    (w_elig[NUM_MASTERS-1:1]),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_rr_winner),
        .o_found  (w_rr_found)
    );

    always_ff @(posedge clk25MHz or negedge reset_L) begin
        if (!reset_L) begin
            r_state       <= ARB_IDLE;
            r_ack         <= '0;
            r_blocked     <= '0;
            r_owner       <= '0;
            r_rr_ptr      <= OWNER_W'(1);
            r_owner_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_fair_cnt    <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_timeout <= 1'b0;
            r_blocked <= r_blocked & bus.req;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state       <= ARB_GRANT;
                        r_ack         <= NUM_MASTERS'(1) << w_winner;
                        r_owner       <= w_winner;
                        r_owner_valid <= 1'b1;
                        r_hold_cnt    <= '0;
                        if (w_pick0) begin
                            if (!w_others)
                                r_fair_cnt <= '0;
                            else if (r_fair_cnt != FAIR_W'(FAIR_LIMIT))
                                r_fair_cnt <= r_fair_cnt + FAIR_W'(1);
                        end else begin
                            r_fair_cnt <= '0;
                            r_rr_ptr   <= w_rr_next;
                        end
                    end
                end
                ARB_GRANT: begin
                    // A voluntary release wins over a watchdog trip on the same cycle.
                    if (!w_owner_req) begin
                        r_state       <= ARB_TURN;
                        r_ack         <= '0;
                        r_owner_valid <= 1'b0;
                    end else if (w_trip) begin
                        r_state       <= ARB_TURN;
                        r_ack         <= '0;
                        r_owner_valid <= 1'b0;
                        r_timeout     <= 1'b1;
                        r_blocked     <= (r_blocked & bus.req) | (NUM_MASTERS'(1) << r_owner);
                    end else if (!bus.bus_wait) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ARB_TURN: r_state <= ARB_IDLE;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.owner       = r_owner;
    assign bus.owner_valid = r_owner_valid;
    assign bus.timeout     = r_timeout;
endmodule
